// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART word loader: receiver state encoding and
// the default timing / end-of-program constants.
// Optional feature macro: UART_PARITY_EN (8E1 framing with a parity state).
package uart_loader_pkg;

  // 100 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // End-of-program marker; sliced down to the configured word width.
  localparam logic [63:0] DEFAULT_END_WORD = 64'h0000_0000_0000_0FFF;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
`ifdef UART_PARITY_EN
    RX_PAR   = 3'd3,
`endif
    RX_STOP  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-flop input synchroniser plus a mid-bit sampling FSM.
// Emits a one-cycle byte_valid with byte_data, or a one-cycle byte_err when
// the stop bit (or, with UART_PARITY_EN, the even parity bit) is wrong.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       wb_clk_i,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync_q1;
  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_d, err_d;
  logic             bit_done, half_done;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses <= so both flops sample the pre-edge values.
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_q1 <= rx_i;
      rx_s    <= sync_q1;
    end
  end

  // Receiver state, bit timer, shift register and registered strobes.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_valid <= valid_d;
      byte_err   <= err_d;
    end
  end

  assign byte_data = shift_q;
  assign bit_done  = (cnt_q == BIT_LAST);
  assign half_done = (cnt_q == HALF_LAST);

  // Next-state logic: re-check start at half a bit, then sample every bit time.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (half_done) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = RX_PAR;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PAR: begin
        if (bit_done) begin
          cnt_d = '0;
          if (rx_s != ^shift_q) begin
            err_d   = 1'b1;
            state_d = RX_IDLE;
          end else begin
            state_d = RX_STOP;
          end
        end
      end
`endif
      RX_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) valid_d = 1'b1;
          else      err_d   = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_word_loader.sv
// UART program loader: assembles received bytes little-endian into words and
// writes them to sequential addresses until the END_WORD marker arrives or
// the target memory is full. Optional macro: UART_PARITY_EN (8E1 frames).
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int                CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int                WORD_W       = 32,
  parameter int                ADDR_W       = 10,
  parameter logic [WORD_W-1:0] END_WORD     = DEFAULT_END_WORD[WORD_W-1:0]
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              rx_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              prog_done_o,
  output logic              frame_err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_err;
  logic [IDX_W-1:0]  byte_idx_q;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_next;
  logic [ADDR_W-1:0] addr_q;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .wb_clk_i   (wb_clk_i),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err)
  );

  // Partial word with the incoming byte merged into its little-endian lane.
  always_comb begin
    word_next = word_q;
    word_next[{byte_idx_q, 3'b000} +: 8] = byte_data;
  end

  // Assembler, write strobe, address/count tracking and status flags.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      // NOTE: the partial word is cleared on reset so a mid-word reset leaves
      // no stale bytes behind; it is a handful of flops, not a RAM.
      byte_idx_q  <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
      prog_done_o <= 1'b0;
      frame_err_o <= 1'b0;
      word_cnt_o  <= '0;
    end else begin
      mem_we_o <= 1'b0;
      // Post-write bookkeeping; the last address stops the load instead of wrapping.
      if (mem_we_o) begin
        word_cnt_o <= word_cnt_o + 1'b1;
        if (addr_q == '1) prog_done_o <= 1'b1;
        else              addr_q      <= addr_q + 1'b1;
      end
      if (!prog_done_o) begin
        if (byte_err) frame_err_o <= 1'b1;
        if (byte_valid) begin
          word_q <= word_next;
          if (byte_idx_q == IDX_LAST) begin
            byte_idx_q <= '0;
            if (word_next == END_WORD) begin
              prog_done_o <= 1'b1;
            end else begin
              mem_we_o    <= 1'b1;
              mem_wdata_o <= word_next;
            end
          end else begin
            byte_idx_q <= byte_idx_q + 1'b1;
          end
        end
      end
    end
  end

  assign mem_addr_o = addr_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader (CLKS_PER_BIT=8, WORD_W=32, ADDR_W=4).
// Table of whole-word vectors plus hand sequences for framing, glitch, reset
// and (with UART_PARITY_EN) parity corner cases.
module tb_uart_word_loader;

  localparam int CPB = 8;

  logic        wb_clk_i = 1'b0;
  logic        rst_n    = 1'b0;
  logic        rx_i     = 1'b1;
  logic        mem_we_o;
  logic [3:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        prog_done_o;
  logic        frame_err_o;
  logic [4:0]  word_cnt_o;

  uart_word_loader #(
    .CLKS_PER_BIT (CPB),
    .WORD_W       (32),
    .ADDR_W       (4)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .prog_done_o (prog_done_o),
    .frame_err_o (frame_err_o),
    .word_cnt_o  (word_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  // Monitor: counts strobes, captures write contents, checks pulse shape.
  int          we_cnt = 0;
  int          bv_cnt = 0;
  int          lat_err = 0;
  int          width_err = 0;
  logic [3:0]  cap_addr = '0;
  logic [31:0] cap_data = '0;
  logic        done_next = 1'b0;
  logic        prev_we = 1'b0;
  logic        prev_bv = 1'b0;

  always @(negedge wb_clk_i) begin
    if (dut.byte_valid) bv_cnt++;
    if (mem_we_o) begin
      we_cnt++;
      cap_addr = mem_addr_o;
      cap_data = mem_wdata_o;
      if (!prev_bv) lat_err++;
      if (prev_we)  width_err++;
    end
    if (prev_we) done_next = prog_done_o;
    prev_we = mem_we_o;
    prev_bv = dut.byte_valid;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) rx_i = 1'b1;
`endif
    send_bit(stop);
    idle(16);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
  endtask

  typedef struct {
    logic        rst_before;
    logic [31:0] word;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [4:0]  exp_cnt;
    logic        exp_done;
  } vec_t;

  vec_t vecs[23];
  int   we0;
  int   bv0;

  initial begin
    // Single word, then three words plus END marker and a trailing word.
    vecs[0] = '{1'b1, 32'h1234_5678, 1'b1, 4'd0, 5'd1, 1'b0};
    vecs[1] = '{1'b1, 32'h1111_1111, 1'b1, 4'd0, 5'd1, 1'b0};
    vecs[2] = '{1'b0, 32'h2222_2222, 1'b1, 4'd1, 5'd2, 1'b0};
    vecs[3] = '{1'b0, 32'h3333_3333, 1'b1, 4'd2, 5'd3, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0FFF, 1'b0, 4'd0, 5'd3, 1'b1};
    vecs[5] = '{1'b0, 32'h4444_4444, 1'b0, 4'd0, 5'd3, 1'b1};
    // Fill all 16 addresses, then one word past full.
    for (int i = 0; i < 16; i++)
      vecs[6+i] = '{(i == 0), 32'hA500_0000 + 32'(i * 32'h0101), 1'b1, 4'(i), 5'(i + 1), (i == 15)};
    vecs[22] = '{1'b0, 32'hBEEF_0001, 1'b0, 4'd0, 5'd16, 1'b1};

    // Reset state.
    idle(3);
    check("rst_we",    {63'd0, mem_we_o},    64'd0);
    check("rst_addr",  {60'd0, mem_addr_o},  64'd0);
    check("rst_wdata", {32'd0, mem_wdata_o}, 64'd0);
    check("rst_done",  {63'd0, prog_done_o}, 64'd0);
    check("rst_err",   {63'd0, frame_err_o}, 64'd0);
    check("rst_cnt",   {59'd0, word_cnt_o},  64'd0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 23; i++) begin
      if (vecs[i].rst_before) do_reset();
      we0 = we_cnt;
      send_word(vecs[i].word);
      idle(8);
      check($sformatf("v%0d_we_count", i), 64'(we_cnt - we0), {63'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        check($sformatf("v%0d_addr", i), {60'd0, cap_addr}, {60'd0, vecs[i].exp_addr});
        check($sformatf("v%0d_wdata", i), {32'd0, cap_data}, {32'd0, vecs[i].word});
        check($sformatf("v%0d_done_next", i), {63'd0, done_next}, {63'd0, vecs[i].exp_done});
      end
      check($sformatf("v%0d_cnt", i), {59'd0, word_cnt_o}, {59'd0, vecs[i].exp_cnt});
      check($sformatf("v%0d_done", i), {63'd0, prog_done_o}, {63'd0, vecs[i].exp_done});
    end
    check("full_no_wrap_addr", {60'd0, mem_addr_o}, 64'd15);

    // Bad stop bit, then four good bytes complete one word at address 0.
    do_reset();
    bv0 = bv_cnt;
    we0 = we_cnt;
    send_byte(8'h99, 1'b0, 1'b0);
    idle(40);
    check("ferr_set",     {63'd0, frame_err_o}, 64'd1);
    check("ferr_dropped", 64'(bv_cnt - bv0), 64'd0);
    send_word(32'hCAFE_F00D);
    idle(8);
    check("ferr_we_count", 64'(we_cnt - we0), 64'd1);
    check("ferr_addr",     {60'd0, cap_addr}, 64'd0);
    check("ferr_wdata",    {32'd0, cap_data}, 64'h0000_0000_CAFE_F00D);
    check("ferr_sticky",   {63'd0, frame_err_o}, 64'd1);
    check("ferr_cnt",      {59'd0, word_cnt_o}, 64'd1);

    // Short low glitch is rejected without error.
    do_reset();
    bv0 = bv_cnt;
    we0 = we_cnt;
    rx_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    idle(40);
    check("glitch_no_byte", 64'(bv_cnt - bv0), 64'd0);
    check("glitch_no_err",  {63'd0, frame_err_o}, 64'd0);

    // Reset mid-word discards the partial bytes.
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    check("midword_no_write", 64'(we_cnt - we0), 64'd0);
    do_reset();
    send_word(32'hAABB_CCDD);
    idle(8);
    check("midrst_we_count", 64'(we_cnt - we0), 64'd1);
    check("midrst_addr",     {60'd0, cap_addr}, 64'd0);
    check("midrst_wdata",    {32'd0, cap_data}, 64'h0000_0000_AABB_CCDD);
    check("midrst_cnt",      {59'd0, word_cnt_o}, 64'd1);

`ifdef UART_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1.
    do_reset();
    bv0 = bv_cnt;
    send_byte(8'h07, 1'b1, 1'b1);
    check("par_bad_err",  {63'd0, frame_err_o}, 64'd1);
    check("par_bad_drop", 64'(bv_cnt - bv0), 64'd0);
    send_byte(8'h07, 1'b1, 1'b0);
    check("par_good_accept", 64'(bv_cnt - bv0), 64'd1);
`endif

    check("we_latency_errs", 64'(lat_err), 64'd0);
    check("we_width_errs",   64'(width_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_loader.md
UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868 (100 MHz / 115200 baud), clock cycles per UART bit, legal minimum 4.
REQ-002 Parameter WORD_W, default 32, width of the assembled memory word, a multiple of 8 between 8 and 64.
REQ-003 Parameter ADDR_W, default 10, word-address width, giving a target depth of 2^ADDR_W words.
REQ-004 Parameter END_WORD, default 32'h0000_0FFF zero-extended/truncated to WORD_W, the end-of-program marker word.
REQ-005 wb_clk_i  input  1  the single clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 rx_i  input  1  UART serial line (idle high, 8N1), asynchronous to wb_clk_i.
REQ-008 mem_we_o  output  1  one-cycle write strobe.
REQ-009 mem_addr_o  output  ADDR_W  word address for the write.
REQ-010 mem_wdata_o  output  WORD_W  assembled word.
REQ-011 prog_done_o  output  1  level, program loaded; held until reset.
REQ-012 frame_err_o  output  1  sticky error: stop-bit or parity error seen.
REQ-013 word_cnt_o  output  ADDR_W+1  count of words written.

Function
REQ-014 rx_i SHALL pass through a 2-flop synchroniser, and all decoding SHALL use the synchronised value.
REQ-015 The receiver FSM SHALL use the states RX_IDLE, RX_START, RX_DATA, RX_PAR (with UART_PARITY_EN only) and RX_STOP.
REQ-016 In RX_IDLE, a synchronised low SHALL enter RX_START; at CLKS_PER_BIT/2 the line SHALL be re-sampled, with high returning to RX_IDLE as a glitch and low entering RX_DATA.
REQ-017 Each data bit SHALL be sampled every CLKS_PER_BIT cycles from mid-start, LSB first, for 8 bits.
REQ-018 In RX_STOP, a sample of 1 SHALL produce a one-cycle byte_valid; a sample of 0 SHALL discard the byte, set frame_err_o and return to RX_IDLE.
REQ-019 The assembler SHALL pack bytes little-endian, with the first byte into [7:0].
REQ-020 After WORD_W/8 bytes, the assembler SHALL issue one write: mem_we_o=1 for exactly one cycle, with mem_addr_o/mem_wdata_o valid in that cycle.
REQ-021 Write latency from the byte_valid of the last byte to mem_we_o SHALL be 1 cycle.
REQ-022 After each write, mem_addr_o SHALL increment, and word_cnt_o SHALL increment.
REQ-023 An assembled word equal to END_WORD SHALL NOT be written; instead prog_done_o SHALL rise the next cycle.
REQ-024 A write to address 2^ADDR_W-1 SHALL assert prog_done_o the cycle after that write (depth full), with no address wrap.
REQ-025 Once prog_done_o=1, all further rx traffic SHALL be ignored: no writes and no counter change.
REQ-026 A framing error SHALL NOT reset the partial-word byte index; the receiver SHALL resync on the next start bit.

Reset
REQ-027 When rst_n=0 at a clock edge, all outputs SHALL be 0, both FSMs SHALL go idle, and the byte index and address SHALL be 0, including reset mid-byte or mid-word, where the partial data is discarded.
REQ-028 The synchroniser flops SHALL reset to 1 (idle line).

Configuration
REQ-029 Macro UART_PARITY_EN: when defined, the frame SHALL be 8E1; RX_PAR SHALL sample the parity bit, and on an even-parity mismatch the byte SHALL be discarded and frame_err_o set.
REQ-030 When UART_PARITY_EN is undefined, the frame SHALL be 8N1 and RX_PAR logic SHALL be absent.

Structure
REQ-031 Package uart_loader_pkg SHALL hold the rx state enum, the default END_WORD and the default CLKS_PER_BIT.
REQ-032 A sub-module uart_rx (synchroniser, receiver FSM, byte_valid/byte_data/err outputs) SHALL be instantiated by uart_word_loader, which keeps the assembler/address logic.

Verification (CLKS_PER_BIT=8, WORD_W=32, ADDR_W=4 unless stated)
REQ-033 Send bytes 78 56 34 12 -> one mem_we_o pulse with addr 0, wdata 32'h12345678, word_cnt_o=1.
REQ-034 Send 3 words, then FF 0F 00 00 -> 3 writes at addrs 0..2; prog_done_o=1; no 4th write; word_cnt_o=3.
REQ-035 Send 16 non-END words -> last write at addr 15; prog_done_o=1 the next cycle; a 17th word produces no write.
REQ-036 Byte with stop bit forced 0, followed by 4 valid bytes -> frame_err_o=1 stays high; the bad byte is dropped; one write containing the 4 valid bytes.
REQ-037 3-cycle low glitch on rx_i -> no byte_valid, no error; assert rst_n=0 after 2 bytes of a word, release, then send 4 bytes -> write at addr 0 with only the new bytes.
REQ-038 With UART_PARITY_EN, byte 0x07 sent with parity 0 -> frame_err_o=1 and no byte accepted; sent with parity 1 -> accepted.
